// File: rtl/keypad_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_if
// Purpose  : Key request handshake between a key source (switches, test
//            sequencer, bench) and the keypad emulator queue.
// Signals  : key_code  [3:0] key to press (0-9, 10 = esp, 11 = *, 12-15 bad)
//            key_valid       request valid
//            key_ready       queue can accept
// Modports : master (key source), slave (keypad emulator)
// Revision : 1.0  initial release
// ============================================================================
interface keypad_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;

  modport master (
    output key_code,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    output key_ready
  );
endinterface
`default_nettype wire

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : keypad_emulator
// Purpose  : Keypad-side model of a 4x3 matrix keypad. Queued key presses are
//            played onto the row lines, gated by the scanner column strobes,
//            with pseudo-random contact bounce on press and release.
// Ports    : clk             system clock, rising edge
//            rst_n           asynchronous active-low reset
//            kif (slave)     key_code / key_valid / key_ready request queue
//            col_in   [3:0]  column strobes from scanner, active-low
//            row_out  [3:0]  row lines to scanner, active-low
//            busy            press in progress or queue not empty
//            cur_key  [3:0]  key currently being played
//            contact         current contact state (1 = closed)
//            bad_code        one-cycle pulse: invalid code dropped
// Revision : 1.0  initial release
// ============================================================================
module keypad_emulator #(
  parameter int BOUNCE_CYC = 16,
  parameter int HOLD_CYC   = 1000,
  parameter int GAP_CYC    = 500
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  keypad_if.slave         kif,
  input  wire logic [3:0] col_in,
  output logic      [3:0] row_out,
  output logic            busy,
  output logic      [3:0] cur_key,
  output logic            contact,
  output logic            bad_code
);

  // Counter reload values: each phase counts down to zero, so load length-1.
  localparam logic [19:0] c_bounce_ld = 20'(BOUNCE_CYC - 1);
  localparam logic [19:0] c_hold_ld   = 20'(HOLD_CYC - 1);
  localparam logic [19:0] c_gap_ld    = 20'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BOUNCE_DN = 3'd1,
    S_HOLD      = 3'd2,
    S_BOUNCE_UP = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t      r_state, w_next_state;
  logic [19:0] r_cnt, w_next_cnt;
  logic [7:0]  r_lfsr;
  logic [3:0]  r_cur_key;
  logic        r_bad_code;

  logic [3:0]  r_mem [4];
  logic [1:0]  r_wr_ptr, r_rd_ptr;
  logic [2:0]  r_count;

  logic        w_accept, w_code_ok, w_push, w_pop;
  logic [1:0]  w_row, w_col;

  // ---------------------------------------------------------------- queue
  // Ready comes from the registered count only, so a pop frees a slot for
  // the request side one cycle later.
  assign kif.key_ready = (r_count != 3'd4);
  assign w_accept      = kif.key_valid && kif.key_ready;
  assign w_code_ok     = (kif.key_code < 4'd12);
  assign w_push        = w_accept && w_code_ok;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= kif.key_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_bad_code <= 1'b0;
    end else begin
      r_bad_code <= w_accept && !w_code_ok;
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 20'd0;
      r_cur_key <= 4'd0;
      r_lfsr    <= 8'hA5;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_pop) r_cur_key <= r_mem[r_rd_ptr];
      // x^8+x^6+x^5+x^4+1, advanced only while bouncing
      if (r_state == S_BOUNCE_DN || r_state == S_BOUNCE_UP)
        r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != 3'd0) begin
          w_next_state = S_BOUNCE_DN;
          w_next_cnt   = c_bounce_ld;
          w_pop        = 1'b1;
        end
      end
      S_BOUNCE_DN: begin
        if (r_cnt == 20'd0) begin
          w_next_state = S_HOLD;
          w_next_cnt   = c_hold_ld;
        end else begin
          w_next_cnt = r_cnt - 20'd1;
        end
      end
      S_HOLD: begin
        if (r_cnt == 20'd0) begin
          w_next_state = S_BOUNCE_UP;
          w_next_cnt   = c_bounce_ld;
        end else begin
          w_next_cnt = r_cnt - 20'd1;
        end
      end
      S_BOUNCE_UP: begin
        if (r_cnt == 20'd0) begin
          w_next_state = S_GAP;
          w_next_cnt   = c_gap_ld;
        end else begin
          w_next_cnt = r_cnt - 20'd1;
        end
      end
      S_GAP: begin
        if (r_cnt == 20'd0) begin
          w_next_state = S_IDLE;
          w_next_cnt   = 20'd0;
        end else begin
          w_next_cnt = r_cnt - 20'd1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 20'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------- contact
  // The last bounce cycle is pinned so the contact settles cleanly into
  // HOLD (closed) and into GAP (open).
  always_comb begin
    contact = 1'b0;
    case (r_state)
      S_BOUNCE_DN: contact = (r_cnt == 20'd0) ? 1'b1 : r_lfsr[0];
      S_HOLD:      contact = 1'b1;
      S_BOUNCE_UP: contact = (r_cnt == 20'd0) ? 1'b0 : r_lfsr[0];
      default:     contact = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- matrix
  always_comb begin
    w_row = 2'd0;
    w_col = 2'd0;
    case (r_cur_key)
      4'd1:    begin w_row = 2'd0; w_col = 2'd0; end
      4'd2:    begin w_row = 2'd0; w_col = 2'd1; end
      4'd3:    begin w_row = 2'd0; w_col = 2'd2; end
      4'd4:    begin w_row = 2'd1; w_col = 2'd0; end
      4'd5:    begin w_row = 2'd1; w_col = 2'd1; end
      4'd6:    begin w_row = 2'd1; w_col = 2'd2; end
      4'd7:    begin w_row = 2'd2; w_col = 2'd0; end
      4'd8:    begin w_row = 2'd2; w_col = 2'd1; end
      4'd9:    begin w_row = 2'd2; w_col = 2'd2; end
      4'd0:    begin w_row = 2'd3; w_col = 2'd1; end
      4'd10:   begin w_row = 2'd3; w_col = 2'd2; end
      4'd11:   begin w_row = 2'd3; w_col = 2'd0; end
      default: begin w_row = 2'd0; w_col = 2'd0; end
    endcase
  end

  // Row 0 / column 0 sit on bit 3 of their buses; col_in[0] is never
  // selected because the column index stops at 2.
  always_comb begin
    row_out = 4'hF;
    if (contact && !col_in[2'd3 - w_col])
      row_out[2'd3 - w_row] = 1'b0;
  end

  assign busy     = (r_state != S_IDLE) || (r_count != 3'd0);
  assign cur_key  = r_cur_key;
  assign bad_code = r_bad_code;

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_emulator
// Purpose  : Directed self-checking bench for keypad_emulator with a
//            scoreboard of expected keys and a reference bounce LFSR.
// Revision : 1.0  initial release
// ============================================================================
module tb_keypad_emulator;
  localparam int B = 4;
  localparam int H = 8;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       busy;
  logic [3:0] cur_key;
  logic       contact;
  logic       bad_code;

  keypad_if kif();

  keypad_emulator #(
    .BOUNCE_CYC(B),
    .HOLD_CYC  (H),
    .GAP_CYC   (G)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .kif     (kif),
    .col_in  (col_in),
    .row_out (row_out),
    .busy    (busy),
    .cur_key (cur_key),
    .contact (contact),
    .bad_code(bad_code)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] sb[$];
  logic [7:0] m_lfsr;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    m_lfsr = 8'hA5;
  endtask

  // One-cycle request; valid codes become expected playback entries.
  task automatic send_key(input logic [3:0] code);
    kif.key_code  = code;
    kif.key_valid = 1'b1;
    if (code < 4'd12) sb.push_back(code);
    step();
    kif.key_valid = 1'b0;
  endtask

  // Advance to the BOUNCE_DN entry edge and compare against the scoreboard.
  task automatic start_press();
    logic [3:0] exp_key;
    step();
    if (sb.size() != 0) begin
      exp_key = sb.pop_front();
      check4("cur_key", cur_key, exp_key);
    end else begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end
  endtask

  // Full press from E0+1: bounce, hold, release bounce, gap, back to idle.
  task automatic run_press(input logic [3:0] row_closed);
    logic exp_c;
    start_press();
    for (int i = 0; i < B; i++) begin
      exp_c = (i == B - 1) ? 1'b1 : m_lfsr[0];
      check1("contact_dn", contact, exp_c);
      check4("row_dn", row_out, exp_c ? row_closed : 4'hF);
      step();
      m_lfsr = lfsr_next(m_lfsr);
    end
    for (int i = 0; i < H; i++) begin
      check1("contact_hold", contact, 1'b1);
      check4("row_hold", row_out, row_closed);
      step();
    end
    for (int i = 0; i < B; i++) begin
      exp_c = (i == B - 1) ? 1'b0 : m_lfsr[0];
      check1("contact_up", contact, exp_c);
      check4("row_up", row_out, exp_c ? row_closed : 4'hF);
      step();
      m_lfsr = lfsr_next(m_lfsr);
    end
    for (int i = 0; i < G; i++) begin
      check1("contact_gap", contact, 1'b0);
      check1("busy_gap", busy, 1'b1);
      step();
    end
    check1("busy_end", busy, 1'b0);
    check4("row_end", row_out, 4'hF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    col_in = 4'b1011;
    apply_reset();

    // Reset values
    check1("rst_ready", kif.key_ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check4("rst_cur_key", cur_key, 4'd0);
    check1("rst_contact", contact, 1'b0);
    check1("rst_bad_code", bad_code, 1'b0);
    check4("rst_row", row_out, 4'hF);

    // Invalid code: handshake completes, pulse, no playback
    kif.key_code  = 4'd13;
    kif.key_valid = 1'b1;
    check1("bad_ready", kif.key_ready, 1'b1);
    step();
    kif.key_valid = 1'b0;
    check1("bad_pulse", bad_code, 1'b1);
    check1("bad_busy", busy, 1'b0);
    check4("bad_row", row_out, 4'hF);
    step();
    check1("bad_pulse_end", bad_code, 1'b0);
    check1("bad_busy2", busy, 1'b0);
    check4("bad_cur_key", cur_key, 4'd0);
    check4("bad_row2", row_out, 4'hF);

    // Key 5 on its own column, then on the wrong columns
    col_in = 4'b1011;
    send_key(4'd5);
    check1("busy_e0", busy, 1'b1);
    check1("contact_e0", contact, 1'b0);
    run_press(4'b1011);

    col_in = 4'b0111;
    send_key(4'd5);
    run_press(4'hF);

    col_in = 4'b1101;
    send_key(4'd5);
    run_press(4'hF);

    // esp sits on row 3 / col 2
    col_in = 4'b1101;
    send_key(4'd10);
    run_press(4'b1110);

    // Fill the queue while key 7 is holding
    col_in = 4'b1011;
    send_key(4'd7);
    start_press();
    repeat (B) begin
      step();
      m_lfsr = lfsr_next(m_lfsr);
    end
    check1("fill_hold_contact", contact, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      kif.key_code  = k[3:0];
      kif.key_valid = 1'b1;
      sb.push_back(k[3:0]);
      step();
      check1("fill_ready", kif.key_ready, (k == 4) ? 1'b0 : 1'b1);
    end
    kif.key_code  = 4'd6;
    kif.key_valid = 1'b1;
    // Key 7 reaches IDLE at E1+2B+H+G, key 1 pops on the next edge.
    begin
      int n;
      n = (2 * B + H + G + 1) - (B + 4);
      for (int i = 1; i <= n; i++) begin
        step();
        check1("wait_ready", kif.key_ready, (i == n) ? 1'b1 : 1'b0);
      end
    end
    if (sb.size() != 0) begin
      logic [3:0] exp_key;
      exp_key = sb.pop_front();
      check4("pop_cur_key", cur_key, exp_key);
    end
    sb.push_back(4'd6);
    step();
    kif.key_valid = 1'b0;
    check1("refill_ready", kif.key_ready, 1'b0);
    check1("refill_busy", busy, 1'b1);

    // Reset in the middle of a held key 8
    col_in = 4'b1011;
    apply_reset();
    check1("rst2_busy", busy, 1'b0);
    send_key(4'd8);
    start_press();
    repeat (B) step();
    check4("k8_hold_row", row_out, 4'b1101);
    #2 rst_n = 1'b0;
    #1;
    check4("async_rst_row", row_out, 4'hF);
    check1("async_rst_contact", contact, 1'b0);
    check1("async_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check1("post_rst_busy", busy, 1'b0);
    check1("post_rst_ready", kif.key_ready, 1'b1);
    check4("post_rst_cur_key", cur_key, 4'd0);
    step();
    step();
    check1("post_rst_idle", busy, 1'b0);
    check4("post_rst_row", row_out, 4'hF);
    check4("post_rst_key", cur_key, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
